// File: rtl/add_1bit_half.sv
// Single-bit half adder with an optional valid-qualified output pipeline
// and saturating sample/carry statistics counters.
module add_1bit_half #(
  parameter int LATENCY   = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 A,
  input  logic                 B,
  input  logic                 in_valid,
  input  logic                 clr_cnt,
  output logic                 O,
  output logic                 C,
  output logic                 out_valid,
  output logic [CNT_WIDTH-1:0] vld_count,
  output logic [CNT_WIDTH-1:0] carry_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  if (LATENCY < 0 || LATENCY > 4) begin : g_bad_latency
    $error("add_1bit_half: LATENCY must be 0..4");
  end

  if (CNT_WIDTH < 2 || CNT_WIDTH > 32) begin : g_bad_cnt_width
    $error("add_1bit_half: CNT_WIDTH must be 2..32");
  end

  logic sum_c;
  logic carry_c;

  assign sum_c   = A ^ B;
  assign carry_c = A & B;

  if (LATENCY == 0) begin : g_comb
    assign O         = sum_c;
    assign C         = carry_c;
    assign out_valid = in_valid;
  end else begin : g_pipe
    logic [LATENCY-1:0] o_q;
    logic [LATENCY-1:0] c_q;
    logic [LATENCY-1:0] v_q;

    // Free-running shift chain; in_valid only rides along as a tag.
    always_ff @(posedge clk) begin
      if (reset) begin
        o_q <= '0;
        c_q <= '0;
        v_q <= '0;
      end else begin
        o_q[0] <= sum_c;
        c_q[0] <= carry_c;
        v_q[0] <= in_valid;
        for (int i = 1; i < LATENCY; i++) begin
          o_q[i] <= o_q[i-1];
          c_q[i] <= c_q[i-1];
          v_q[i] <= v_q[i-1];
        end
      end
    end

    assign O         = o_q[LATENCY-1];
    assign C         = c_q[LATENCY-1];
    assign out_valid = v_q[LATENCY-1];
  end

  // Counters sit at the acceptance stage and saturate instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset || clr_cnt) begin
      vld_count   <= '0;
      carry_count <= '0;
    end else begin
      if (in_valid && vld_count != CNT_MAX) begin
        vld_count <= vld_count + CNT_ONE;
      end
      if (in_valid && carry_c && carry_count != CNT_MAX) begin
        carry_count <= carry_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_add_1bit_half.sv
// Bench for add_1bit_half: four latency/width variants share one stimulus
// stream and are checked against a sample-history reference model.
module tb_add_1bit_half;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic A = 1'b0;
  logic B = 1'b0;
  logic in_valid = 1'b0;
  logic clr_cnt = 1'b0;

  always #5 clk = ~clk;

  logic o0, c0, v0, o1, c1, v1, o2, c2, v2, o3, c3, v3;
  logic [15:0] vc0, cc0, vc1, cc1, vc2, cc2;
  logic [3:0]  vc3, cc3;

  add_1bit_half #(.LATENCY(0), .CNT_WIDTH(16)) d0 (
    .clk(clk), .reset(reset), .A(A), .B(B), .in_valid(in_valid),
    .clr_cnt(clr_cnt), .O(o0), .C(c0), .out_valid(v0),
    .vld_count(vc0), .carry_count(cc0));

  add_1bit_half #(.LATENCY(1), .CNT_WIDTH(16)) d1 (
    .clk(clk), .reset(reset), .A(A), .B(B), .in_valid(in_valid),
    .clr_cnt(clr_cnt), .O(o1), .C(c1), .out_valid(v1),
    .vld_count(vc1), .carry_count(cc1));

  add_1bit_half #(.LATENCY(2), .CNT_WIDTH(16)) d2 (
    .clk(clk), .reset(reset), .A(A), .B(B), .in_valid(in_valid),
    .clr_cnt(clr_cnt), .O(o2), .C(c2), .out_valid(v2),
    .vld_count(vc2), .carry_count(cc2));

  add_1bit_half #(.LATENCY(3), .CNT_WIDTH(4)) d3 (
    .clk(clk), .reset(reset), .A(A), .B(B), .in_valid(in_valid),
    .clr_cnt(clr_cnt), .O(o3), .C(c3), .out_valid(v3),
    .vld_count(vc3), .carry_count(cc3));

  int checks = 0;
  int errors = 0;

  // hist_sum[k]/hist_vld[k]: arithmetic sum A+B and valid of the sample
  // taken k+1 edges ago; a reset edge wipes the whole history.
  int hist_sum [4];
  int hist_vld [4];
  int n16_v = 0, n16_c = 0, n4_v = 0, n4_c = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic a_i, input logic b_i,
                            input logic v_i, input logic r_i,
                            input logic c_i);
    int s;
    s = int'(a_i) + int'(b_i);
    if (r_i) begin
      for (int k = 0; k < 4; k++) begin
        hist_sum[k] = 0;
        hist_vld[k] = 0;
      end
    end else begin
      for (int k = 3; k > 0; k--) begin
        hist_sum[k] = hist_sum[k-1];
        hist_vld[k] = hist_vld[k-1];
      end
      hist_sum[0] = s;
      hist_vld[0] = int'(v_i);
    end
    if (r_i || c_i) begin
      n16_v = 0; n16_c = 0; n4_v = 0; n4_c = 0;
    end else if (v_i) begin
      n16_v = (n16_v < 65535) ? n16_v + 1 : 65535;
      n4_v  = (n4_v < 15) ? n4_v + 1 : 15;
      if (s == 2) begin
        n16_c = (n16_c < 65535) ? n16_c + 1 : 65535;
        n4_c  = (n4_c < 15) ? n4_c + 1 : 15;
      end
    end
  endtask

  task automatic step(input logic a_i, input logic b_i, input logic v_i,
                      input logic r_i, input logic c_i);
    int s;
    @(negedge clk);
    A = a_i; B = b_i; in_valid = v_i; reset = r_i; clr_cnt = c_i;
    s = int'(a_i) + int'(b_i);
    #1;
    chk("l0_sum", {30'd0, c0, o0}, s);
    chk("l0_vld", v0, v_i);
    @(posedge clk);
    model_edge(a_i, b_i, v_i, r_i, c_i);
    #1;
    chk("l1_sum", {30'd0, c1, o1}, hist_sum[0]);
    chk("l1_vld", v1, hist_vld[0]);
    chk("l2_sum", {30'd0, c2, o2}, hist_sum[1]);
    chk("l2_vld", v2, hist_vld[1]);
    chk("l3_sum", {30'd0, c3, o3}, hist_sum[2]);
    chk("l3_vld", v3, hist_vld[2]);
    chk("l0_vcnt", vc0, n16_v);
    chk("l0_ccnt", cc0, n16_c);
    chk("l1_vcnt", vc1, n16_v);
    chk("l1_ccnt", cc1, n16_c);
    chk("l2_vcnt", vc2, n16_v);
    chk("l2_ccnt", cc2, n16_c);
    chk("l3_vcnt", vc3, n4_v);
    chk("l3_ccnt", cc3, n4_c);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      hist_sum[k] = 0;
      hist_vld[k] = 0;
    end

    // Reset state, then the truth table back to back.
    step(0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Samples during reset are discarded; the first after it counts.
    step(1, 1, 1, 1, 0);
    step(1, 1, 1, 1, 0);
    step(1, 1, 1, 1, 0);
    step(1, 1, 1, 0, 0);
    chk("post_reset_c", c1, 1);
    chk("post_reset_vcnt", vc1, 1);
    chk("post_reset_ccnt", cc1, 1);

    // Lone pulse through the 3-deep chain, then one flushed by reset.
    step(1, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("l3_pulse_c", c3, 1);
    chk("l3_pulse_v", v3, 1);
    step(0, 0, 0, 0, 0);
    chk("l3_pulse_gone", v3, 0);
    step(1, 1, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);

    // Saturation of the 4-bit counters, then clear beats increment.
    for (int i = 0; i < 20; i++) step(1, 1, 1, 0, 0);
    chk("sat_vcnt", vc3, 15);
    chk("sat_ccnt", cc3, 15);
    step(1, 1, 1, 0, 1);
    chk("clr_vcnt", vc3, 0);
    chk("clr_ccnt", cc3, 0);

    // Combinational sweep with in_valid toggling, in and out of reset.
    for (int i = 0; i < 16; i++) begin
      logic [3:0] p;
      p = 4'(i);
      step(p[0], p[1], p[2], p[3], 0);
    end

    // Random traffic with occasional clears and resets.
    for (int i = 0; i < 500; i++) begin
      step(1'($urandom), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 63) == 0), ($urandom_range(0, 47) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
